// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single DataMemory port between the pipeline MEM stage and the UART loader/dumper.
// Define DMEM_ARB_FAIRNESS_EN to force a DMA grant after STARVE_LIMIT contended cycles.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_busy
);

  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  if (MAX_BURST == 0 || STARVE_LIMIT == 0) begin : g_bad_param
    $error("dmem_port_arbiter: MAX_BURST and STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               fair_force;
  logic               own_dma;
  logic               owner_req;
  logic               owner_we;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int unsigned WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Counts consecutive cycles the DMA has been held off by the CPU.
  always_comb begin
    wait_d = '0;
    if (state_q == ST_CPU && state_d == ST_CPU && dma_req && cpu_req) begin
      wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign fair_force = (state_q == ST_CPU) && dma_req && (wait_q == WAIT_LAST);
`else
  assign fair_force = 1'b0;
`endif

  // Ownership transitions; burst counter only runs while the DMA owns the port.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ST_BOOT: begin
        burst_d = '0;
        if (boot_done) begin
          state_d = ST_CPU;
        end
      end
      ST_CPU: begin
        burst_d = '0;
        if ((dma_req && !cpu_req) || fair_force) begin
          state_d = ST_DMA;
        end
      end
      ST_DMA: begin
        if (!dma_req) begin
          state_d = ST_CPU;
        end else begin
          if (cpu_req && burst_q == BURST_LAST) begin
            state_d = ST_CPU;
          end
          if (burst_q != BURST_LAST) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Port mux: zero added latency, the owner drives DataMemory directly.
  assign own_dma   = (state_q != ST_CPU);
  assign owner_req = own_dma ? dma_req : cpu_req;
  assign owner_we  = own_dma ? dma_we  : cpu_we;

  assign mem_addr  = own_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = own_dma ? dma_wdata : cpu_wdata;
  assign mem_we    = owner_req & owner_we;
  assign mem_re    = owner_req & ~owner_we;

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;
  assign dma_gnt   = own_dma;
  assign cpu_stall = own_dma & cpu_req;
  assign boot_busy = (state_q == ST_BOOT);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run against an ownership model.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MAX_BURST    = 8;
  localparam int unsigned STARVE_LIMIT = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int OWN_BOOT = 0;
  localparam int OWN_CPU  = 1;
  localparam int OWN_DMA  = 2;

  logic              clk = 1'b0;
  logic              reset, boot_done;
  logic              cpu_req, cpu_we, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_gnt;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re, boot_busy;

  logic [31:0] dmem    [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: who owns memory, accesses granted this tenure, contended wait cycles.
  int          m_owner  = OWN_BOOT;
  int          m_acc    = 0;
  int          m_starve = 0;
  logic        mo_dma, mo_req, mo_we;
  logic [31:0] mo_addr;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .boot_done(boot_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .boot_busy(boot_busy)
  );

  always #5 clk = ~clk;

  // DataMemory: synchronous write, combinational read.
  assign mem_rdata = dmem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we === 1'b1) dmem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(posedge clk) begin
    mo_dma  = (m_owner != OWN_CPU);
    mo_req  = mo_dma ? dma_req : cpu_req;
    mo_we   = mo_dma ? dma_we : cpu_we;
    mo_addr = mo_dma ? dma_addr : cpu_addr;
    if (mo_req && mo_we) ref_mem[mo_addr[7:0]] = mo_dma ? dma_wdata : cpu_wdata;
    if (!reset) begin
      m_owner = OWN_BOOT; m_acc = 0; m_starve = 0;
    end else if (m_owner == OWN_BOOT) begin
      if (boot_done) m_owner = OWN_CPU;
    end else if (m_owner == OWN_CPU) begin
      if ((dma_req && !cpu_req) || (FAIR && dma_req && m_starve >= int'(STARVE_LIMIT) - 1)) begin
        m_owner = OWN_DMA; m_acc = 0; m_starve = 0;
      end else if (dma_req) begin
        m_starve++;
      end else begin
        m_starve = 0;
      end
    end else begin
      if (!dma_req) begin
        m_owner = OWN_CPU;
      end else begin
        m_acc++;
        if (cpu_req && m_acc >= int'(MAX_BURST)) m_owner = OWN_CPU;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; boot_done = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'hA5A5_0001;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hFFFF_FFFF;
    step(); step();
    #1;
    tests_run++;
    if (boot_busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b exp 1", boot_busy); end
    tests_run++;
    if (dma_gnt !== 1'b1) begin tests_failed++; $display("FAIL reset_gnt: got %b exp 1", dma_gnt); end
    tests_run++;
    if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL reset_we: got %b exp 1", mem_we); end
    tests_run++;
    if (cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall: got %b exp 1", cpu_stall); end
    tests_run++;
    if (mem_addr !== 32'h10 || mem_wdata !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL boot_mux: got %h/%h exp 00000010/a5a50001", mem_addr, mem_wdata);
    end
    reset = 1'b1;
    step();
    #1;
    tests_run++;
    if (boot_busy !== 1'b1) begin tests_failed++; $display("FAIL boot_hold: got %b exp 1", boot_busy); end
  endtask

  task automatic test_boot();
    cpu_req = 1'b0; dma_req = 1'b0; boot_done = 1'b1;
    #1;
    tests_run++;
    if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL boot_idle_we: got %b exp 0", mem_we); end
    step();
    #1;
    tests_run++;
    if (boot_busy !== 1'b0 || dma_gnt !== 1'b0) begin
      tests_failed++; $display("FAIL boot_exit: busy/gnt got %b%b exp 00", boot_busy, dma_gnt);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    tests_run++;
    if (cpu_rdata !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL boot_read: got %h exp a5a50001", cpu_rdata); end
    tests_run++;
    if (mem_re !== 1'b1 || cpu_stall !== 1'b0) begin
      tests_failed++; $display("FAIL cpu_read_ctl: re/stall got %b%b exp 10", mem_re, cpu_stall);
    end
    cpu_addr = 32'h20;
    #1;
    tests_run++;
    if (cpu_rdata !== 32'h0) begin tests_failed++; $display("FAIL boot_cpu_ignored: got %h exp 0", cpu_rdata); end
    boot_done = 1'b0;
    step();
    #1;
    tests_run++;
    if (boot_busy !== 1'b0) begin tests_failed++; $display("FAIL boot_done_fall: got %b exp 0", boot_busy); end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_idle_handoff();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    #1;
    tests_run++;
    if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL handoff_same: got %b exp 0", dma_gnt); end
    step();
    #1;
    tests_run++;
    if (dma_gnt !== 1'b1 || dma_rdata !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL handoff_gnt: got %b/%h exp 1/a5a50001", dma_gnt, dma_rdata);
    end
    dma_req = 1'b0;
    #1;
    tests_run++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      tests_failed++; $display("FAIL handoff_idle: we/re got %b%b exp 00", mem_we, mem_re);
    end
    step();
    #1;
    tests_run++;
    if (dma_gnt !== 1'b0) begin tests_failed++; $display("FAIL handoff_back: got %b exp 0", dma_gnt); end
  endtask

  task automatic test_burst_cap();
    int  acc;
    int  first_run;
    bit  cpu_done;
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hB000_0000;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    acc = 0; first_run = -1; cpu_done = 1'b0;
    for (int c = 0; c < 60 && acc < 20; c++) begin
      dma_addr = 32'h40 + 32'(acc); dma_wdata = 32'hB000_0000 + 32'(acc);
      #1;
      if (dma_gnt === 1'b1) begin
        tests_run++;
        if (cpu_stall !== cpu_req) begin
          tests_failed++; $display("FAIL burst_stall acc %0d: got %b exp %b", acc, cpu_stall, cpu_req);
        end
        acc++;
      end else if (!cpu_done) begin
        first_run = acc; cpu_done = 1'b1;
        tests_run++;
        if (cpu_rdata !== 32'hB000_0000 || cpu_stall !== 1'b0) begin
          tests_failed++; $display("FAIL burst_cpu_access: got %h/%b exp b0000000/0", cpu_rdata, cpu_stall);
        end
        cpu_req = 1'b0;
      end
      step();
    end
    tests_run++;
    if (first_run !== int'(MAX_BURST)) begin tests_failed++; $display("FAIL burst_cap: got %0d exp %0d", first_run, MAX_BURST); end
    tests_run++;
    if (acc !== 20) begin tests_failed++; $display("FAIL burst_resume: got %0d exp 20", acc); end
    dma_req = 1'b0; cpu_req = 1'b0;
    step(); step();
  endtask

  task automatic test_starvation();
    int first;
    int exp_first;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; dma_req = 1'b1; dma_we = 1'b0;
    exp_first = FAIR ? int'(STARVE_LIMIT) : -1;
    first = -1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (dma_gnt === 1'b1) begin first = c; break; end
      step();
    end
    tests_run++;
    if (first !== exp_first) begin tests_failed++; $display("FAIL starvation: first grant cycle %0d exp %0d", first, exp_first); end
    dma_req = 1'b0; cpu_req = 1'b0;
    step(); step();
  endtask

  task automatic test_write_gating();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    step();
    dma_req = 1'b0; dma_we = 1'b1; dma_wdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL gate_we: gnt/we got %b%b exp 10", dma_gnt, mem_we);
    end
    step();
    dma_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    tests_run++;
    if (cpu_rdata !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL gate_mem: got %h exp a5a50001", cpu_rdata); end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_mid_burst_reset();
    int cnt;
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'hC000_0000;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h61;
    for (int n = 0; n < 3; n++) begin
      dma_addr = 32'h60 + 32'(n); dma_wdata = 32'hC000_0000 + 32'(n);
      if (n == 2) begin reset = 1'b0; boot_done = 1'b0; end
      #1;
      tests_run++;
      if (cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL midrst_stall n%0d: got %b exp 1", n, cpu_stall); end
      step();
    end
    #1;
    tests_run++;
    if (boot_busy !== 1'b1 || dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_state: busy/gnt/stall got %b%b%b exp 111", boot_busy, dma_gnt, cpu_stall);
    end
    reset = 1'b1;
    step();
    #1;
    tests_run++;
    if (boot_busy !== 1'b1 || cpu_stall !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_hold: busy/stall got %b%b exp 11", boot_busy, cpu_stall);
    end
    boot_done = 1'b1; dma_req = 1'b0; cpu_req = 1'b0;
    step();
    dma_req = 1'b1; dma_we = 1'b0;
    step();
    cpu_req = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dma_gnt === 1'b1) begin
        cnt++;
      end else begin
        tests_run++;
        if (cpu_rdata !== 32'hC000_0001) begin tests_failed++; $display("FAIL midrst_data: got %h exp c0000001", cpu_rdata); end
        break;
      end
      step();
    end
    tests_run++;
    if (cnt !== int'(MAX_BURST)) begin tests_failed++; $display("FAIL midrst_burst_clear: got %0d exp %0d", cnt, MAX_BURST); end
    cpu_req = 1'b0; dma_req = 1'b0;
    step(); step();
  endtask

  task automatic test_random();
    logic        od, eq, ewe;
    logic [31:0] ea, ew, er;
    logic [164:0] got, exp;
    int          shown;
    shown = 0;
    reset = 1'b0; boot_done = 1'b0;
    step();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(99) != 0);
      boot_done = (c > 8) ? ($urandom_range(15) != 0) : 1'b0;
      if ($urandom_range(9) < 3) cpu_req = ~cpu_req;
      if ($urandom_range(9) < 1) dma_req = ~dma_req;
      cpu_we = 1'($urandom_range(1)); dma_we = 1'($urandom_range(1));
      cpu_addr = 32'($urandom_range(255)); dma_addr = 32'($urandom_range(255));
      cpu_wdata = $urandom; dma_wdata = $urandom;
      #1;
      od  = (m_owner != OWN_CPU);
      eq  = od ? dma_req : cpu_req;
      ewe = od ? dma_we : cpu_we;
      ea  = od ? dma_addr : cpu_addr;
      ew  = od ? dma_wdata : cpu_wdata;
      er  = ref_mem[ea[7:0]];
      exp = {od, od & cpu_req, (m_owner == OWN_BOOT), eq & ewe, eq & ~ewe, ea, ew, er, er};
      got = {dma_gnt, cpu_stall, boot_busy, mem_we, mem_re, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cyc %0d: got %h exp %h", c, got, exp);
        end
      end
      step();
    end
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_idle_handoff();
    test_burst_cap();
    test_starvation();
    test_write_gating();
    test_mid_burst_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
